// File: rtl/reg_wb_pkg.sv
// Shared types and constants for the ARM register-file write side.
// Imported by the writeback top and its priority encoder.
package reg_wb_pkg;

    localparam int NREG    = 16;
    localparam int DATA_W  = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } wb_state_t;

endpackage

// File: rtl/reg_writeback_if.sv
// Load-multiple handshake bundle between the memory side and the
// register-file write block.
interface reg_writeback_if #(
    parameter int DATA_W = 32
);
    logic              ldm_start;
    logic [15:0]       ldm_list;
    logic [DATA_W-1:0] ldm_data;
    logic              ldm_valid;
    logic              ldm_ready;
    logic              ldm_done;

    modport master (
        output ldm_start,
        output ldm_list,
        output ldm_data,
        output ldm_valid,
        input  ldm_ready,
        input  ldm_done
    );

    modport slave (
        input  ldm_start,
        input  ldm_list,
        input  ldm_data,
        input  ldm_valid,
        output ldm_ready,
        output ldm_done
    );
endinterface

// File: rtl/reg_writeback_lowest_set_bit.sv
// 16-to-4 priority encoder: index of the lowest set bit plus a found flag.
// Drives both the first LDM target and every following one.
module lowest_set_bit
    import reg_wb_pkg::*;
(
    input  logic [NREG-1:0] mask,
    output logic [3:0]      idx,
    output logic            found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Scan downward so the lowest set bit is the final assignment.
        for (int i = NREG - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx   = 4'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Write side of the 16x32 register file: single writeback, PC advance
// and an ascending load-multiple sequencer.
module reg_writeback
    import reg_wb_pkg::*;
#(
    parameter int DATA_W  = reg_wb_pkg::DATA_W,
    parameter int PC_STEP = reg_wb_pkg::PC_STEP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [3:0]        wr_reg,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pc_inc,
    reg_writeback_if.slave    ldm,
    output logic              busy,
    output logic [DATA_W-1:0] regupdate_R0,
    output logic [DATA_W-1:0] regupdate_R1,
    output logic [DATA_W-1:0] regupdate_R2,
    output logic [DATA_W-1:0] regupdate_R3,
    output logic [DATA_W-1:0] regupdate_R4,
    output logic [DATA_W-1:0] regupdate_R5,
    output logic [DATA_W-1:0] regupdate_R6,
    output logic [DATA_W-1:0] regupdate_R7,
    output logic [DATA_W-1:0] regupdate_R8,
    output logic [DATA_W-1:0] regupdate_R9,
    output logic [DATA_W-1:0] regupdate_R10,
    output logic [DATA_W-1:0] regupdate_R11,
    output logic [DATA_W-1:0] regupdate_R12,
    output logic [DATA_W-1:0] regupdate_R13,
    output logic [DATA_W-1:0] regupdate_R14,
    output logic [DATA_W-1:0] regupdate_R15
);

    wb_state_t         state_q;
    wb_state_t         state_d;
    logic [NREG-1:0]   pending_q;
    logic [NREG-1:0]   pending_d;
    logic [3:0]        ptr_q;
    logic [3:0]        ptr_d;
    logic [DATA_W-1:0] regs [NREG];

    logic              beat;
    logic [NREG-1:0]   pending_left;
    logic [3:0]        start_idx;
    logic              start_found;
    logic [3:0]        next_idx;
    logic              next_found;

    assign beat         = (state_q == LOAD) && ldm.ldm_valid;
    assign pending_left = pending_q & ~(16'b1 << ptr_q);

    lowest_set_bit u_start_lsb (
        .mask  (ldm.ldm_list),
        .idx   (start_idx),
        .found (start_found)
    );

    lowest_set_bit u_next_lsb (
        .mask  (pending_left),
        .idx   (next_idx),
        .found (next_found)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        ptr_d     = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (ldm.ldm_start) begin
                    if (start_found) begin
                        state_d   = LOAD;
                        pending_d = ldm.ldm_list;
                        ptr_d     = start_idx;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            LOAD: begin
                if (beat) begin
                    pending_d = pending_left;
                    if (next_found) begin
                        ptr_d = next_idx;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ldm.ldm_ready = (state_q == LOAD);
    assign ldm.ldm_done  = (state_q == DONE);
    assign busy          = (state_q == LOAD) || (state_q == DONE);

    // Per-register priority: LDM beat, then wr_en, then PC advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (beat && (ptr_q == 4'(i))) begin
                    regs[i] <= ldm.ldm_data;
                end else if (wr_en && (wr_reg == 4'(i))) begin
                    regs[i] <= wr_data;
                end else if ((i == NREG - 1) && pc_inc) begin
                    regs[i] <= regs[i] + DATA_W'(PC_STEP);
                end
            end
        end
    end

    assign regupdate_R0  = regs[0];
    assign regupdate_R1  = regs[1];
    assign regupdate_R2  = regs[2];
    assign regupdate_R3  = regs[3];
    assign regupdate_R4  = regs[4];
    assign regupdate_R5  = regs[5];
    assign regupdate_R6  = regs[6];
    assign regupdate_R7  = regs[7];
    assign regupdate_R8  = regs[8];
    assign regupdate_R9  = regs[9];
    assign regupdate_R10 = regs[10];
    assign regupdate_R11 = regs[11];
    assign regupdate_R12 = regs[12];
    assign regupdate_R13 = regs[13];
    assign regupdate_R14 = regs[14];
    assign regupdate_R15 = regs[15];

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: directed cases then random traffic
// against a queue-based reference model.
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_reg;
    logic [31:0] wr_data;
    logic        pc_inc;
    logic        busy;
    logic [31:0] ru [16];

    always #5 clk = ~clk;

    reg_writeback_if #(.DATA_W(32)) lif ();

    reg_writeback dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_reg        (wr_reg),
        .wr_data       (wr_data),
        .pc_inc        (pc_inc),
        .ldm           (lif),
        .busy          (busy),
        .regupdate_R0  (ru[0]),
        .regupdate_R1  (ru[1]),
        .regupdate_R2  (ru[2]),
        .regupdate_R3  (ru[3]),
        .regupdate_R4  (ru[4]),
        .regupdate_R5  (ru[5]),
        .regupdate_R6  (ru[6]),
        .regupdate_R7  (ru[7]),
        .regupdate_R8  (ru[8]),
        .regupdate_R9  (ru[9]),
        .regupdate_R10 (ru[10]),
        .regupdate_R11 (ru[11]),
        .regupdate_R12 (ru[12]),
        .regupdate_R13 (ru[13]),
        .regupdate_R14 (ru[14]),
        .regupdate_R15 (ru[15])
    );

    typedef struct packed {
        logic [15:0][31:0] r;
        logic              rdy;
        logic              dn;
        logic              bsy;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;
    int   vectors = 0;
    int   errs    = 0;

    // Reference model: register values plus the list of LDM targets still owed.
    logic [15:0][31:0] m_regs;
    int                m_q [$];
    bit                m_load;
    bit                m_done;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("R%0d", i), ru[i], mon_e.r[i]);
            end
            chk("ldm_ready", 32'(lif.ldm_ready), 32'(mon_e.rdy));
            chk("ldm_done", 32'(lif.ldm_done), 32'(mon_e.dn));
            chk("busy", 32'(busy), 32'(mon_e.bsy));
        end
    end

    task automatic model_clear();
        m_regs = '0;
        m_q.delete();
        m_load = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic model_step(bit we, logic [3:0] wreg, logic [31:0] wd,
                              bit pi, bit st, logic [15:0] lst,
                              logic [31:0] ld, bit lv);
        logic [15:0][31:0] nr;
        exp_t e;
        int   idx;
        bit   acc;
        nr  = m_regs;
        acc = m_load && lv;
        // Later assignments override earlier ones: lowest priority first.
        if (pi) nr[15] = nr[15] + 32'd4;
        if (we) nr[wreg] = wd;
        if (acc) begin
            idx = m_q.pop_front();
            nr[idx] = ld;
        end
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_load) begin
            if (acc && m_q.size() == 0) begin
                m_load = 1'b0;
                m_done = 1'b1;
            end
        end else if (st) begin
            for (int i = 0; i < 16; i++) begin
                if (lst[i]) m_q.push_back(i);
            end
            if (m_q.size() == 0) m_done = 1'b1;
            else m_load = 1'b1;
        end
        m_regs = nr;
        e.r    = nr;
        e.rdy  = m_load;
        e.dn   = m_done;
        e.bsy  = m_load | m_done;
        sb.push_back(e);
    endtask

    task automatic cyc(bit we, logic [3:0] wreg, logic [31:0] wd, bit pi,
                       bit st, logic [15:0] lst, logic [31:0] ld, bit lv);
        @(negedge clk);
        wr_en         = we;
        wr_reg        = wreg;
        wr_data       = wd;
        pc_inc        = pi;
        lif.ldm_start = st;
        lif.ldm_list  = lst;
        lif.ldm_data  = ld;
        lif.ldm_valid = lv;
        model_step(we, wreg, wd, pi, st, lst, ld, lv);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic beat(logic [31:0] d);
        cyc(0, 0, 0, 0, 0, 0, d, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b0;
        wr_en         = 1'b0;
        pc_inc        = 1'b0;
        lif.ldm_start = 1'b0;
        lif.ldm_valid = 1'b0;
        sb.delete();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) chk($sformatf("rst_R%0d", i), ru[i], 32'h0);
        chk("rst_ready", 32'(lif.ldm_ready), 32'h0);
        chk("rst_done", 32'(lif.ldm_done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b0;
        wr_en         = 1'b0;
        wr_reg        = '0;
        wr_data       = '0;
        pc_inc        = 1'b0;
        lif.ldm_start = 1'b0;
        lif.ldm_list  = '0;
        lif.ldm_data  = '0;
        lif.ldm_valid = 1'b0;
        model_clear();
        do_reset();

        cyc(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        idle(1);

        cyc(1, 15, 32'hFFFFFFF8, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 15, 32'h100, 1, 0, 0, 0, 0);
        idle(1);

        cyc(0, 0, 0, 0, 1, 16'h8013, 0, 0);
        beat(32'hA);
        beat(32'hB);
        beat(32'hC);
        beat(32'hD);
        cyc(0, 0, 0, 0, 1, 16'h0001, 32'h1, 1);
        idle(2);

        cyc(0, 0, 0, 0, 1, 16'h8013, 0, 0);
        beat(32'h1A);
        cyc(0, 0, 0, 0, 1, 16'h00FF, 32'hBAD, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'hBAD, 0);
        beat(32'h1B);
        beat(32'h1C);
        cyc(0, 0, 0, 1, 0, 0, 32'h1D, 1);
        idle(2);

        cyc(0, 0, 0, 0, 1, 16'h0004, 0, 0);
        cyc(1, 2, 32'h66, 0, 0, 0, 32'h55, 1);
        idle(2);
        cyc(0, 0, 0, 0, 1, 16'h0004, 0, 0);
        cyc(1, 7, 32'h77, 0, 0, 0, 32'h99, 1);
        idle(2);

        cyc(0, 0, 0, 0, 1, 16'h0000, 0, 0);
        idle(2);

        cyc(0, 0, 0, 0, 1, 16'h00F0, 0, 0);
        beat(32'h44);
        do_reset();
        idle(3);

        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), $urandom,
                $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
                $urandom, $urandom_range(0, 3) != 0);
        end
        idle(40);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
